// File: rtl/oam_dma_ctl_if.sv
// Bus bundle for the sprite-DMA sequencer. It carries the CPU-side request
// signals, the memory read data, and the DMA-side bus drive back to the bus mux.
interface oam_dma_ctl_if;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_rw;
    logic [7:0]  mem_rdata;
    logic        cpu_rdy;
    logic        bus_grant;
    logic [15:0] dma_addr;
    logic [7:0]  dma_wdata;
    logic        dma_rw;
    logic        busy;

    // The DMA controller samples the CPU bus and memory data and drives the DMA bus.
    modport master (
        input  cpu_addr, cpu_wdata, cpu_rw, mem_rdata,
        output cpu_rdy, bus_grant, dma_addr, dma_wdata, dma_rw, busy
    );

    // The CPU, memory and bus mux side of the same bundle.
    modport slave (
        output cpu_addr, cpu_wdata, cpu_rw, mem_rdata,
        input  cpu_rdy, bus_grant, dma_addr, dma_wdata, dma_rw, busy
    );
endinterface

// File: rtl/oam_dma_ctl.sv
// Sprite-DMA sequencer. A CPU write to DMA_REG halts the CPU and copies one
// 256-byte page to OAM_DATA as strictly alternating read and write cycles.
// All outputs decode from registered state only.
module oam_dma_ctl #(
    parameter logic [15:0] DMA_REG  = 16'h4014,
    parameter logic [15:0] OAM_DATA = 16'h2004
) (
    input  logic          clk,
    input  logic          rst,
    oam_dma_ctl_if.master bus
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HALT,
        ST_ALIGN,
        ST_READ,
        ST_WRITE
    } state_t;

    state_t     state_reg;
    state_t     state_next;
    logic [7:0] page_reg;
    logic [7:0] idx_reg;
    logic [7:0] buf_reg;
    logic       cyc_odd_reg;
    logic       trigger;

    // The trigger is only honoured from IDLE; while busy it is dropped, not queued.
    assign trigger = (state_reg == ST_IDLE) && !bus.cpu_rw && (bus.cpu_addr == DMA_REG);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Datapath: cycle parity, source page/index, and the byte held between read and write.
    always_ff @(posedge clk) begin
        if (rst) begin
            cyc_odd_reg <= 1'b0;
            page_reg    <= 8'h00;
            idx_reg     <= 8'h00;
            buf_reg     <= 8'h00;
        end else begin
            cyc_odd_reg <= ~cyc_odd_reg;
            if (trigger) begin
                page_reg <= bus.cpu_wdata;
                idx_reg  <= 8'h00;
            end
            if (state_reg == ST_READ) begin
                buf_reg <= bus.mem_rdata;
            end
            if (state_reg == ST_WRITE) begin
                idx_reg <= idx_reg + 8'h01;
            end
        end
    end

    // Next state. HALT skips ALIGN when it already sits on an odd cycle so that
    // every READ lands on an even cycle.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (trigger) state_next = ST_HALT;
            ST_HALT:  state_next = cyc_odd_reg ? ST_READ : ST_ALIGN;
            ST_ALIGN: state_next = ST_READ;
            ST_READ:  state_next = ST_WRITE;
            ST_WRITE: state_next = (idx_reg == 8'hFF) ? ST_IDLE : ST_READ;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Output decode; the bus is only granted in READ/WRITE so the CPU never
    // loses it mid-access.
    always_comb begin
        bus.cpu_rdy   = (state_reg == ST_IDLE);
        bus.busy      = (state_reg != ST_IDLE);
        bus.bus_grant = (state_reg == ST_READ) || (state_reg == ST_WRITE);
        bus.dma_rw    = (state_reg != ST_WRITE);
        bus.dma_addr  = {page_reg, idx_reg};
        bus.dma_wdata = buf_reg;
        if (state_reg == ST_WRITE) begin
            bus.dma_addr = OAM_DATA;
        end
    end

endmodule
